// File: rtl/cipherx_pkg.sv
// Shared types and constants for the CipherX stream loader.
// The byte-swap helpers serve the CIPHERX_LOADER_BSWAP_EN build option.
package cipherx_pkg;

    localparam int unsigned CIPHERX_DATA_W = 32;
    localparam int unsigned CIPHERX_BLK_W  = 128;
    localparam int unsigned CIPHERX_WORDS  = CIPHERX_BLK_W / CIPHERX_DATA_W;
    localparam int unsigned CIPHERX_IDX_W  = 3;
    localparam int unsigned CIPHERX_CNT_W  = 16;
    localparam int unsigned CIPHERX_OCNT_W = 2;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_DRAIN = 3'd4
    } cipherx_state_e;

    typedef struct packed {
        logic [CIPHERX_BLK_W-1:0] key;
        logic [CIPHERX_BLK_W-1:0] plaintext;
    } cipherx_operands_t;

    function automatic logic [CIPHERX_DATA_W-1:0] bswap32(input logic [CIPHERX_DATA_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Byte-reverses each 32-bit word of a block in place; word order is kept.
    function automatic logic [CIPHERX_BLK_W-1:0] bswap_blk(input logic [CIPHERX_BLK_W-1:0] b);
        logic [CIPHERX_BLK_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < CIPHERX_WORDS; i++) begin
            r[i*CIPHERX_DATA_W +: CIPHERX_DATA_W] = bswap32(b[i*CIPHERX_DATA_W +: CIPHERX_DATA_W]);
        end
        return r;
    endfunction

endpackage

// File: rtl/cipherx_word_packer.sv
// Shift-in register assembling key (words 0-3) and plaintext (words 4-7),
// MS word first, plus the 3-bit accepted-word index.
module cipherx_word_packer
    import cipherx_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       load_en_i,
    input  logic                       clear_i,
    input  logic [CIPHERX_DATA_W-1:0]  word_i,
    output cipherx_operands_t          ops_o,
    output logic [CIPHERX_IDX_W-1:0]   idx_next_c,
    output logic                       last_word_c
);

    logic [CIPHERX_IDX_W-1:0] idx_q;

    always_comb begin
        idx_next_c  = idx_q;
        last_word_c = 1'b0;
        if (clear_i) begin
            idx_next_c = '0;
        end else if (load_en_i) begin
            idx_next_c  = idx_q + CIPHERX_IDX_W'(1);
            last_word_c = (idx_q == CIPHERX_IDX_W'(7));
        end
    end

    // Index bit 2 selects plaintext; shifting left lands word 0 in the MS slot.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx_q <= '0;
            ops_o <= '0;
        end else begin
            idx_q <= idx_next_c;
            if (load_en_i && !clear_i) begin
                if (!idx_q[2]) begin
                    ops_o.key <= {ops_o.key[CIPHERX_BLK_W-CIPHERX_DATA_W-1:0], word_i};
                end else begin
                    ops_o.plaintext <= {ops_o.plaintext[CIPHERX_BLK_W-CIPHERX_DATA_W-1:0], word_i};
                end
            end
        end
    end

endmodule

// File: rtl/cipherx_stream_loader.sv
// Word-serial loader/unloader around the 128-bit AES core.
// Optional CIPHERX_LOADER_BSWAP_EN byte-reverses every stream word in and out.
module cipherx_stream_loader
    import cipherx_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [CIPHERX_DATA_W-1:0]  s_data_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [CIPHERX_DATA_W-1:0]  m_data_o,
    output logic                       m_last_o,
    output logic                       aes_start_o,
    output logic [CIPHERX_BLK_W-1:0]   aes_key_o,
    output logic [CIPHERX_BLK_W-1:0]   aes_plaintext_o,
    input  logic                       aes_done_i,
    input  logic [CIPHERX_BLK_W-1:0]   aes_ciphertext_i,
    output logic                       busy_o,
    output logic [CIPHERX_CNT_W-1:0]   blk_cnt_o
);

    cipherx_state_e              state_q, state_d;
    cipherx_operands_t           ops;
    logic [CIPHERX_DATA_W-1:0]   word_in;
    logic [CIPHERX_BLK_W-1:0]    ct_in;
    logic [CIPHERX_BLK_W-1:0]    obuf_q;
    logic [CIPHERX_OCNT_W-1:0]   out_cnt_q;
    logic [CIPHERX_IDX_W-1:0]    idx_next;
    logic                        last_word;
    logic                        accept_c;
    logic                        out_hs_c;
    logic                        blk_done_c;
    logic                        s_ready_d, aes_start_d, m_valid_d, busy_d;

`ifdef CIPHERX_LOADER_BSWAP_EN
    assign word_in = bswap32(s_data_i);
    assign ct_in   = bswap_blk(aes_ciphertext_i);
`else
    assign word_in = s_data_i;
    assign ct_in   = aes_ciphertext_i;
`endif

    assign accept_c   = s_valid_i && s_ready_o;
    assign out_hs_c   = m_valid_o && m_ready_i;
    assign blk_done_c = out_hs_c && m_last_o;

    cipherx_word_packer u_packer (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .load_en_i   (accept_c),
        .clear_i     (blk_done_c),
        .word_i      (word_in),
        .ops_o       (ops),
        .idx_next_c  (idx_next),
        .last_word_c (last_word)
    );

    assign aes_key_o       = ops.key;
    assign aes_plaintext_o = ops.plaintext;
    assign m_data_o        = obuf_q[CIPHERX_BLK_W-1 -: CIPHERX_DATA_W];

    // Next state; registered outputs are decoded from the next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (last_word)  state_d = ST_START;
            ST_START:                 state_d = ST_WAIT;
            ST_WAIT:  if (aes_done_i) state_d = ST_CAPT;
            ST_CAPT:                  state_d = ST_DRAIN;
            ST_DRAIN: if (blk_done_c) state_d = ST_LOAD;
            default:                  state_d = ST_LOAD;
        endcase
        s_ready_d   = (state_d == ST_LOAD);
        aes_start_d = (state_d == ST_START);
        m_valid_d   = (state_d == ST_DRAIN);
        busy_d      = !((state_d == ST_LOAD) && (idx_next == '0));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_LOAD;
            s_ready_o   <= 1'b1;
            aes_start_o <= 1'b0;
            m_valid_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_ready_o   <= s_ready_d;
            aes_start_o <= aes_start_d;
            m_valid_o   <= m_valid_d;
            busy_o      <= busy_d;
        end
    end

    // Output buffer shifts left so m_data_o is always a flop slice.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            obuf_q    <= '0;
            out_cnt_q <= '0;
            m_last_o  <= 1'b0;
            blk_cnt_o <= '0;
        end else if (state_q == ST_CAPT) begin
            obuf_q    <= ct_in;
            out_cnt_q <= '0;
            m_last_o  <= 1'b0;
        end else if (out_hs_c) begin
            obuf_q    <= {obuf_q[CIPHERX_BLK_W-CIPHERX_DATA_W-1:0], CIPHERX_DATA_W'(0)};
            out_cnt_q <= out_cnt_q + CIPHERX_OCNT_W'(1);
            m_last_o  <= (out_cnt_q == CIPHERX_OCNT_W'(2));
            if (m_last_o) begin
                blk_cnt_o <= blk_cnt_o + CIPHERX_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cipherx_stream_loader.sv
// Scoreboard bench for cipherx_stream_loader with a behavioural stand-in AES core
// returning known FIPS-197 ciphertexts. Honours CIPHERX_LOADER_BSWAP_EN.
module tb_cipherx_stream_loader;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [31:0]   s_data_i;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [31:0]   m_data_o;
    logic          m_last_o;
    logic          aes_start_o;
    logic [127:0]  aes_key_o;
    logic [127:0]  aes_plaintext_o;
    logic          aes_done_i;
    logic [127:0]  aes_ciphertext_i;
    logic          busy_o;
    logic [15:0]   blk_cnt_o;

    cipherx_stream_loader dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .s_valid_i        (s_valid_i),
        .s_ready_o        (s_ready_o),
        .s_data_i         (s_data_i),
        .m_valid_o        (m_valid_o),
        .m_ready_i        (m_ready_i),
        .m_data_o         (m_data_o),
        .m_last_o         (m_last_o),
        .aes_start_o      (aes_start_o),
        .aes_key_o        (aes_key_o),
        .aes_plaintext_o  (aes_plaintext_o),
        .aes_done_i       (aes_done_i),
        .aes_ciphertext_i (aes_ciphertext_i),
        .busy_o           (busy_o),
        .blk_cnt_o        (blk_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } exp_t;

    exp_t          q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            start_cnt = 0;
    int            core_lat  = 2;
    bit            stall_en  = 1'b0;
    bit            spur_en   = 1'b0;
    bit            spur_force = 1'b0;
    logic          core_done = 1'b0;
    logic          spur_done = 1'b0;
    logic [127:0]  exp_key, exp_pt, exp_ct;

    assign aes_done_i = core_done | spur_done;

    function automatic logic [31:0] swap_w(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Stream-side view of a word: reversed when the loader expects little-endian words.
    function automatic logic [31:0] bus_w(input logic [31:0] w);
`ifdef CIPHERX_LOADER_BSWAP_EN
        return swap_w(w);
`else
        return w;
`endif
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        int guard;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid_i = 1'b0;
                s_data_i  = $urandom;
                @(negedge clk_i);
            end
        end
        s_valid_i = 1'b1;
        s_data_i  = w;
        guard = 0;
        while (!s_ready_o && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_ready timeout: waited %0d cycles", guard);
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Sends 8 words; returns at the negedge after the 8th acceptance with s_valid_i low.
    task automatic send_block(input logic [127:0] k, input logic [127:0] p,
                              input logic [127:0] c, input bit rnd, input bit push);
        logic [31:0] w;
        exp_key = k;
        exp_pt  = p;
        exp_ct  = c;
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                w = c[127-32*i -: 32];
                q.push_back({(i == 3), bus_w(w)});
            end
        end
        @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            w = (i < 4) ? k[127-32*i -: 32] : p[127-32*(i-4) -: 32];
            send_word(bus_w(w), rnd);
        end
        s_valid_i = 1'b0;
        s_data_i  = 32'hdead_beef;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (!(q.size() == 0 && s_ready_o && !busy_o && !m_valid_o) && n < bound) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= bound) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: timeout after %0d cycles, %0d words pending", n, q.size());
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            if (aes_start_o) start_cnt++;
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            spur_done = spur_force ||
                        (spur_en && (s_ready_o || m_valid_o) && ($urandom_range(0, 1) == 1));
        end
    end

    // Stand-in AES core: checks operands, then done; ciphertext valid only the cycle after.
    initial begin
        bit aborted;
        aes_ciphertext_i = '0;
        forever begin
            @(negedge clk_i);
            if (aes_start_o && rst_n_i) begin
                chk("start key", aes_key_o, exp_key);
                chk("start plaintext", aes_plaintext_o, exp_pt);
                aborted = 1'b0;
                for (int i = 0; i < core_lat; i++) begin
                    @(negedge clk_i);
                    if (!rst_n_i) aborted = 1'b1;
                    if (aborted) break;
                end
                if (!aborted) begin
                    core_done = 1'b1;
                    @(negedge clk_i);
                    core_done        = 1'b0;
                    aes_ciphertext_i = exp_ct;
                    chk("capt key stable", aes_key_o, exp_key);
                    chk("capt m_valid low", 128'(m_valid_o), 128'h0);
                    @(negedge clk_i);
                    aes_ciphertext_i = 128'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;
                    chk("m_valid at D+2", 128'(m_valid_o), 128'h1);
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every handshake, checks hold under back-pressure.
    initial begin
        exp_t        e;
        int          widx, stall_left;
        bit          have_prev, nxt;
        logic [31:0] prev_data;
        logic        prev_last;
        m_ready_i  = 1'b1;
        widx       = 0;
        stall_left = 5;
        have_prev  = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk_i);
            nxt = 1'b1;
            if (!rst_n_i) begin
                widx       = 0;
                stall_left = 5;
                have_prev  = 1'b0;
            end else begin
                if (m_valid_o) begin
                    if (have_prev) begin
                        chk("hold m_data", 128'(m_data_o), 128'(prev_data));
                        chk("hold m_last", 128'(m_last_o), 128'(prev_last));
                    end
                    if (m_ready_i) begin
                        if (q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected word: got %h expected none", m_data_o);
                        end else begin
                            e = q.pop_front();
                            chk("m_data", 128'(m_data_o), 128'(e.data));
                            chk("m_last", 128'(m_last_o), 128'(e.last));
                        end
                        widx = (widx == 3) ? 0 : widx + 1;
                        if (widx == 0) stall_left = 5;
                        have_prev = 1'b0;
                    end else begin
                        have_prev = 1'b1;
                        prev_data = m_data_o;
                        prev_last = m_last_o;
                    end
                end else begin
                    have_prev = 1'b0;
                end
                if (stall_en && widx == 2 && stall_left > 0) begin
                    nxt = 1'b0;
                    stall_left--;
                end
            end
            @(posedge clk_i);
            #1 m_ready_i = nxt;
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, " s_ready"}, 128'(s_ready_o), 128'h1);
        chk({tag, " busy"}, 128'(busy_o), 128'h0);
        chk({tag, " m_valid"}, 128'(m_valid_o), 128'h0);
        chk({tag, " m_last"}, 128'(m_last_o), 128'h0);
        chk({tag, " m_data"}, 128'(m_data_o), 128'h0);
        chk({tag, " aes_start"}, 128'(aes_start_o), 128'h0);
        chk({tag, " key"}, aes_key_o, 128'h0);
        chk({tag, " plaintext"}, aes_plaintext_o, 128'h0);
        chk({tag, " blk_cnt"}, 128'(blk_cnt_o), 128'h0);
    endtask

    initial begin
        int sc;
        rst_n_i   = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        repeat (3) @(negedge clk_i);
        check_reset_values("reset");
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // FIPS-197 vector, back-to-back words
        sc = start_cnt;
        send_block(K1, P1, C1, 1'b0, 1'b1);
        chk("start after 8th word", 128'(aes_start_o), 128'h1);
        chk("s_ready low in START", 128'(s_ready_o), 128'h0);
        chk("busy in START", 128'(busy_o), 128'h1);
        wait_done(100);
        chk("blk_cnt after 1", 128'(blk_cnt_o), 128'h1);
        chk("one start pulse b2b", 128'(start_cnt - sc), 128'h1);

        // Gappy input plus spurious done in LOAD and DRAIN
        spur_en = 1'b1;
        sc = start_cnt;
        send_block(K1, P1, C1, 1'b1, 1'b1);
        wait_done(200);
        spur_en = 1'b0;
        chk("blk_cnt after 2", 128'(blk_cnt_o), 128'h2);
        chk("one start pulse rnd", 128'(start_cnt - sc), 128'h1);

        // Spurious done while idle
        spur_force = 1'b1;
        @(negedge clk_i);
        spur_force = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("idle spur s_ready", 128'(s_ready_o), 128'h1);
        chk("idle spur busy", 128'(busy_o), 128'h0);
        chk("idle spur start", 128'(start_cnt - sc), 128'h1);

        // Back-pressure on word 2
        stall_en = 1'b1;
        send_block(K2, P2, C2, 1'b0, 1'b1);
        wait_done(200);
        stall_en = 1'b0;
        chk("blk_cnt after 3", 128'(blk_cnt_o), 128'h3);

        // Reset while waiting on the core
        core_lat = 30;
        send_block(K2, P2, C2, 1'b0, 1'b0);
        repeat (2) @(negedge clk_i);
        chk("wait busy", 128'(busy_o), 128'h1);
        chk("wait s_ready", 128'(s_ready_o), 128'h0);
        #2 rst_n_i = 1'b0;
        #1 check_reset_values("async reset");
        repeat (3) @(negedge clk_i);
        rst_n_i  = 1'b1;
        core_lat = 2;
        send_block(K1, P1, C1, 1'b0, 1'b1);
        wait_done(100);
        chk("blk_cnt after reset", 128'(blk_cnt_o), 128'h1);

`ifdef CIPHERX_LOADER_BSWAP_EN
        // Counter wrap: fresh reset then 65536 blocks
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i  = 1'b1;
        core_lat = 1;
        for (int b = 0; b < 65536; b++) begin
            send_block(K1, P1, C1, 1'b0, 1'b1);
            wait_done(100);
            if (b == 65534) chk("blk_cnt at ffff", 128'(blk_cnt_o), 128'hffff);
        end
        chk("blk_cnt wrap", 128'(blk_cnt_o), 128'h0);
`endif

        chk("scoreboard empty", 128'(q.size()), 128'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
